// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: in-order word fetch from instruction memory into a prefetch queue,
// with redirect flush, in-flight response discard and in-band address/alignment faults.
module instr_fetch_ctrl #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] TEXT_ORG  = 32'h0000_1000,
    parameter logic [31:0] TEXT_END  = 32'h0000_2000,
    parameter logic [31:0] RESET_PC  = TEXT_ORG,
    parameter logic [31:0] FAULT_NOP = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_fault_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [31:0]      e_pc  [DEPTH];
    logic [31:0]      e_ins [DEPTH];
    logic [DEPTH-1:0] e_flt;
    logic [DEPTH-1:0] e_fil;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [AW-1:0]    fptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    pend;
    logic [CW-1:0]    discard;
    logic [31:0]      pc;
    logic             halted;
    logic             in_range;
    logic             pop;
    logic             want;
    logic             issue;
    logic             fault;
    logic             drop;
    logic             fill;
    logic [CW:0]      used;

    always_comb begin
        in_range      = pc[1:0] == 2'b00 && pc >= TEXT_ORG && pc <= TEXT_END - 32'd4;
        instr_valid_o = rst_ni && e_fil[head] && !redirect_i;
        pop           = instr_valid_o && instr_ready_i;
        // a head popped this cycle frees its slot for a same-cycle issue
        used          = {1'b0, count} - (CW+1)'(pop) + {1'b0, discard};
        want          = rst_ni && used < (CW+1)'(DEPTH) && !halted && !redirect_i;
        issue         = want && in_range;
        fault         = want && !in_range;
        drop          = mem_rvalid_i && discard != '0;
        fill          = mem_rvalid_i && discard == '0 && pend != '0;
        mem_req_o     = issue;
        mem_addr_o    = pc;
        instr_o       = e_ins[head];
        instr_pc_o    = e_pc[head];
        instr_fault_o = e_flt[head];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_pc[i]  <= '0;
                e_ins[i] <= '0;
            end
            e_flt   <= '0;
            e_fil   <= '0;
            head    <= '0;
            tail    <= '0;
            fptr    <= '0;
            count   <= '0;
            pend    <= '0;
            discard <= '0;
            pc      <= RESET_PC;
            halted  <= 1'b0;
        end else if (redirect_i) begin
            // every still-unfilled entry has a response on its way that must be dropped
            e_fil   <= '0;
            head    <= '0;
            tail    <= '0;
            fptr    <= '0;
            count   <= '0;
            pend    <= '0;
            discard <= discard + pend - CW'(drop | fill);
            pc      <= redirect_pc_i;
            halted  <= 1'b0;
        end else begin
            if (drop)
                discard <= discard - CW'(1);
            if (fill) begin
                e_ins[fptr] <= mem_rdata_i;
                e_fil[fptr] <= 1'b1;
                fptr        <= fptr + AW'(1);
            end
            if (pop) begin
                e_fil[head] <= 1'b0;
                head        <= head + AW'(1);
            end
            if (issue || fault) begin
                e_pc[tail]  <= pc;
                e_flt[tail] <= fault;
                e_fil[tail] <= fault;
                tail        <= tail + AW'(1);
            end
            if (fault) begin
                e_ins[tail] <= FAULT_NOP;
                halted      <= 1'b1;
            end
            if (issue)
                pc <= pc + 32'd4;
            count <= count + CW'(issue | fault) - CW'(pop);
            pend  <= pend + CW'(issue) - CW'(fill);
        end
    end

    // a response with nothing outstanding means the memory broke its one-response-per-request contract
    a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_rvalid_i |-> (discard != '0 || pend != '0));

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: randomized and directed checks of instr_fetch_ctrl against a
// queue-based reference model and an address-hashed memory model.
module tb_instr_fetch_ctrl;
    localparam int          D    = 2;
    localparam logic [31:0] ORG  = 32'h0000_1000;
    localparam logic [31:0] TEND = 32'h0000_1100;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_fault_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    instr_fetch_ctrl #(.DEPTH(D), .TEXT_ORG(ORG), .TEXT_END(TEND), .RESET_PC(ORG), .FAULT_NOP(NOP)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o),
        .instr_pc_o(instr_pc_o), .instr_fault_o(instr_fault_o), .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] pc; logic [31:0] ins; logic flt; logic fil; } ent_t;
    typedef struct { logic [31:0] addr; int due; } req_t;

    ent_t        q[$];
    req_t        mq[$];
    logic [31:0] m_pc;
    bit          m_halt;
    int          m_disc;
    int          last_due;
    int          now;
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          ready;
    bit          redirect;
    logic [31:0] rpc;
    int          total = 0;
    int          bad = 0;
    logic        o_req, o_valid, o_fault;
    logic [31:0] o_addr, o_pc, o_ins;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // one clock: drive inputs, compare against the model mid-cycle, advance model and memory
    task automatic cycle();
        logic        rv, ev, er, inr, want, pop;
        logic [31:0] rd;
        int          used, unf, idx;
        rv = mq.size() > 0 && mq[0].due <= now;
        rd = rv ? memfn(mq[0].addr) : $urandom;
        mem_rvalid_i  = rv;
        mem_rdata_i   = rd;
        redirect_i    = redirect;
        redirect_pc_i = rpc;
        instr_ready_i = ready;
        #1;
        ev   = !redirect && q.size() > 0 && q[0].fil;
        pop  = ev && ready;
        used = q.size() - int'(pop) + m_disc;
        inr  = m_pc[1:0] == 2'b00 && m_pc >= ORG && m_pc <= TEND - 4;
        want = used < D && !m_halt && !redirect;
        er   = want && inr;
        total++;
        if (mem_req_o !== er) begin bad++; $display("FAIL req t=%0d got=%b exp=%b", now, mem_req_o, er); end
        total++;
        if (mem_addr_o !== m_pc) begin bad++; $display("FAIL addr t=%0d got=%h exp=%h", now, mem_addr_o, m_pc); end
        total++;
        if (instr_valid_o !== ev) begin bad++; $display("FAIL valid t=%0d got=%b exp=%b", now, instr_valid_o, ev); end
        if (ev) begin
            total++;
            if (instr_o !== q[0].ins) begin bad++; $display("FAIL instr t=%0d got=%h exp=%h", now, instr_o, q[0].ins); end
            total++;
            if (instr_pc_o !== q[0].pc) begin bad++; $display("FAIL pc t=%0d got=%h exp=%h", now, instr_pc_o, q[0].pc); end
            total++;
            if (instr_fault_o !== q[0].flt) begin bad++; $display("FAIL fault t=%0d got=%b exp=%b", now, instr_fault_o, q[0].flt); end
        end
        o_req = mem_req_o; o_addr = mem_addr_o; o_valid = instr_valid_o;
        o_pc = instr_pc_o; o_ins = instr_o; o_fault = instr_fault_o;
        if (redirect) begin
            unf = 0;
            foreach (q[i]) if (!q[i].fil) unf++;
            m_disc = m_disc + unf - int'(rv);
            q.delete();
            m_pc   = rpc;
            m_halt = 1'b0;
        end else begin
            if (rv) begin
                if (m_disc > 0) m_disc--;
                else begin
                    idx = -1;
                    foreach (q[i]) if (idx < 0 && !q[i].fil) idx = i;
                    if (idx >= 0) begin q[idx].ins = rd; q[idx].fil = 1'b1; end
                end
            end
            if (pop) void'(q.pop_front());
            if (want && inr) q.push_back('{pc: m_pc, ins: 32'h0, flt: 1'b0, fil: 1'b0});
            if (want && !inr) begin
                q.push_back('{pc: m_pc, ins: NOP, flt: 1'b1, fil: 1'b1});
                m_halt = 1'b1;
            end
            if (er) m_pc = m_pc + 32'd4;
        end
        if (rv) void'(mq.pop_front());
        if (mem_req_o === 1'b1) begin
            int due;
            due = now + int'($urandom_range(lat_lo, lat_hi));
            if (due <= last_due) due = last_due + 1;
            mq.push_back('{addr: mem_addr_o, due: due});
            last_due = due;
        end
        @(posedge clk_i);
        #1;
        now++;
    endtask

    task automatic reset_on();
        rst_ni = 1'b0; redirect = 1'b0; ready = 1'b0;
        redirect_i = 1'b0; instr_ready_i = 1'b0; mem_rvalid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    task automatic reset_off();
        q.delete(); mq.delete();
        m_pc = ORG; m_halt = 1'b0; m_disc = 0; last_due = -1;
        rst_ni = 1'b1;
    endtask

    task automatic do_reset();
        reset_on();
        reset_off();
    endtask

    task automatic test_reset();
        reset_on();
        total++;
        if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid_o); end
        total++;
        if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", mem_req_o); end
        total++;
        if (instr_fault_o !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b exp=0", instr_fault_o); end
        total++;
        if (instr_o !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr_o); end
        total++;
        if (instr_pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", instr_pc_o); end
        total++;
        if (mem_addr_o !== ORG) begin bad++; $display("FAIL rst_addr got=%h exp=%h", mem_addr_o, ORG); end
        reset_off();
    endtask

    task automatic test_free_run();
        int first, nval;
        do_reset();
        ready = 1'b1; lat_lo = 1; lat_hi = 1;
        first = -1; nval = 0;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (i < 3) begin
                total++;
                if (o_req !== 1'b1 || o_addr !== ORG + 32'(4 * i)) begin
                    bad++; $display("FAIL run_addr i=%0d got=%b/%h exp=1/%h", i, o_req, o_addr, ORG + 32'(4 * i));
                end
            end
            if (o_valid && first < 0) begin
                first = i;
                total++;
                if (o_pc !== ORG) begin bad++; $display("FAIL run_first_pc got=%h exp=%h", o_pc, ORG); end
            end
            if (i >= 2 && o_valid) nval++;
        end
        total++;
        if (first != 2) begin bad++; $display("FAIL run_first_cycle got=%0d exp=2", first); end
        total++;
        if (nval != 12) begin bad++; $display("FAIL run_rate got=%0d exp=12", nval); end
    endtask

    task automatic test_backpressure();
        int nreq, ndel;
        logic [31:0] exp;
        do_reset();
        ready = 1'b0; lat_lo = 1; lat_hi = 1;
        nreq = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (o_req) nreq++;
        end
        total++;
        if (nreq != 2) begin bad++; $display("FAIL bp_reqs got=%0d exp=2", nreq); end
        ready = 1'b1; exp = ORG; ndel = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (o_valid) begin
                ndel++;
                total++;
                if (o_pc !== exp || o_ins !== memfn(exp)) begin
                    bad++; $display("FAIL bp_order got=%h/%h exp=%h/%h", o_pc, o_ins, exp, memfn(exp));
                end
                exp = exp + 32'd4;
            end
        end
        total++;
        if (ndel != 8) begin bad++; $display("FAIL bp_count got=%0d exp=8", ndel); end
    endtask

    task automatic wait_first(input string name, input logic [31:0] tgt);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycle();
            if (o_valid) begin
                seen = 1'b1;
                total++;
                if (o_pc !== tgt || o_ins !== memfn(tgt) || o_fault !== 1'b0) begin
                    bad++; $display("FAIL %s got=%h/%h/%b exp=%h/%h/0", name, o_pc, o_ins, o_fault, tgt, memfn(tgt));
                end
            end
        end
        if (!seen) begin total++; bad++; $display("FAIL %s timeout got=none exp=%h", name, tgt); end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        ready = 1'b0; lat_lo = 3; lat_hi = 3;
        cycle(); cycle();
        redirect = 1'b1; rpc = ORG + 32'h40;
        cycle();
        total++;
        if (o_valid !== 1'b0 || o_req !== 1'b0) begin bad++; $display("FAIL rdi_quiet got=%b/%b exp=0/0", o_valid, o_req); end
        redirect = 1'b0; ready = 1'b1;
        wait_first("rdi_first", ORG + 32'h40);
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        ready = 1'b1; lat_lo = 1; lat_hi = 1;
        repeat (5) cycle();
        redirect = 1'b1; rpc = ORG + 32'h80;
        cycle();
        total++;
        if (o_valid !== 1'b0 || o_req !== 1'b0) begin bad++; $display("FAIL rdv_quiet got=%b/%b exp=0/0", o_valid, o_req); end
        redirect = 1'b0;
        wait_first("rdv_first", ORG + 32'h80);
    endtask

    task automatic test_fault();
        int nreq, nval;
        do_reset();
        ready = 1'b1; lat_lo = 1; lat_hi = 1;
        redirect = 1'b1; rpc = ORG + 32'h2;
        cycle();
        redirect = 1'b0;
        nreq = 0; nval = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (o_req) nreq++;
            if (o_valid) begin
                nval++;
                total++;
                if (o_fault !== 1'b1 || o_ins !== NOP || o_pc !== ORG + 32'h2) begin
                    bad++; $display("FAIL flt_entry got=%b/%h/%h exp=1/%h/%h", o_fault, o_ins, o_pc, NOP, ORG + 32'h2);
                end
            end
        end
        total++;
        if (nreq != 0) begin bad++; $display("FAIL flt_noreq got=%0d exp=0", nreq); end
        total++;
        if (nval != 1) begin bad++; $display("FAIL flt_count got=%0d exp=1", nval); end
        redirect = 1'b1; rpc = ORG;
        cycle();
        redirect = 1'b0;
        cycle();
        total++;
        if (o_req !== 1'b1 || o_addr !== ORG) begin bad++; $display("FAIL flt_resume got=%b/%h exp=1/%h", o_req, o_addr, ORG); end
    endtask

    task automatic test_text_end();
        logic [31:0] epc[3];
        logic        eflt[3];
        int          ndel;
        epc[0] = TEND - 32'd8; epc[1] = TEND - 32'd4; epc[2] = TEND;
        eflt[0] = 1'b0; eflt[1] = 1'b0; eflt[2] = 1'b1;
        do_reset();
        ready = 1'b1; lat_lo = 1; lat_hi = 1;
        redirect = 1'b1; rpc = TEND - 32'd8;
        cycle();
        redirect = 1'b0; ndel = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (o_req) begin
                total++;
                if (o_addr >= TEND) begin bad++; $display("FAIL end_req got=%h exp=<%h", o_addr, TEND); end
            end
            if (o_valid) begin
                if (ndel < 3) begin
                    total++;
                    if (o_pc !== epc[ndel] || o_fault !== eflt[ndel] || o_ins !== (eflt[ndel] ? NOP : memfn(epc[ndel]))) begin
                        bad++; $display("FAIL end_entry k=%0d got=%h/%b/%h exp=%h/%b", ndel, o_pc, o_fault, o_ins, epc[ndel], eflt[ndel]);
                    end
                end
                ndel++;
            end
        end
        total++;
        if (ndel != 3) begin bad++; $display("FAIL end_count got=%0d exp=3", ndel); end
    endtask

    task automatic test_random();
        logic [31:0] t;
        do_reset();
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            ready    = $urandom_range(0, 3) != 0;
            redirect = $urandom_range(0, 15) == 0;
            t = ORG - 32'd8 + 32'($urandom_range(0, 72) * 4);
            if ($urandom_range(0, 7) == 0) t = t + 32'($urandom_range(1, 3));
            rpc = t;
            cycle();
        end
        redirect = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        now = 0;
        test_reset();
        test_free_run();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_rvalid();
        test_fault();
        test_text_end();
        test_random();
        test_reset();
        test_free_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
